// File: rtl/p_emap_gather.sv
// Element-map gather: splits column indices into word/lane, reads the packed vector memory
// and streams one gathered row per chunk over a valid/ready interface with backpressure.
module p_emap_gather #(
  parameter int unsigned      LANES      = 8,
  parameter int unsigned      UNITS      = 8,
  parameter int unsigned      ELEM_W     = 32,
  parameter int unsigned      IDX_W      = 32,
  parameter int unsigned      MAX_CHUNKS = 4,
  parameter int unsigned      MEM_DEPTH  = 1024,
  parameter logic [IDX_W-1:0] INVALID    = '1,
  parameter int unsigned      CNT_W      = $clog2(MAX_CHUNKS) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [$clog2(MEM_DEPTH)-1:0]      wr_addr,
  input  logic [UNITS*ELEM_W-1:0]           wr_data,
  input  logic                              start,
  output logic                              start_ready,
  input  logic [MAX_CHUNKS*LANES*IDX_W-1:0] col_nos,
  input  logic [CNT_W-1:0]                  no_of_multiples,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*ELEM_W-1:0]           out_row,
  output logic [CNT_W-1:0]                  out_chunk,
  output logic                              out_last,
  output logic                              oob_err,
  output logic                              busy
);

  localparam int unsigned      AW        = $clog2(MEM_DEPTH);
  localparam int unsigned      WORD_W    = UNITS * ELEM_W;
  localparam int unsigned      CHUNK_W   = LANES * IDX_W;
  localparam int unsigned      COL_W     = MAX_CHUNKS * CHUNK_W;
  localparam int unsigned      SHIFT     = $clog2(UNITS);
  localparam int unsigned      RW        = (SHIFT > 0) ? SHIFT : 1;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH);
  localparam logic [IDX_W-1:0] OFF_MASK  = IDX_W'(UNITS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_CHUNKS);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e state_q, state_d;

  logic [WORD_W-1:0] mem [MEM_DEPTH];
  logic [COL_W-1:0]  col_q;
  logic [CNT_W-1:0]  n_q, n_start, issue_q, issue_sel;
  logic              oob_q;

  logic              s1_valid_q, s1_last_q;
  logic [CNT_W-1:0]  s1_chunk_q;
  logic [AW-1:0]     s1_word_q [LANES];
  logic [RW-1:0]     s1_off_q  [LANES];
  logic [LANES-1:0]  s1_inv_q;

  logic              s2_valid_q, s2_last_q;
  logic [CNT_W-1:0]  s2_chunk_q;
  logic [WORD_W-1:0] s2_data_q [LANES];
  logic [RW-1:0]     s2_off_q  [LANES];
  logic [LANES-1:0]  s2_inv_q;

  logic [COL_W-1:0]   col_sh;
  logic [CHUNK_W-1:0] chunk_idx;
  logic [AW-1:0]      word_d [LANES];
  logic [RW-1:0]      off_d  [LANES];
  logic [LANES-1:0]   inv_d, oob_d;
  logic               advance, issue_en, issue_last, accept_start, wr_ok;

  // The whole pipeline freezes while a presented row is refused.
  assign advance      = !(s2_valid_q && !out_ready);
  assign issue_en     = (state_q == StIssue) && advance;
  assign issue_last   = (issue_q == n_q - CNT_W'(1));
  assign accept_start = start && (state_q == StIdle);
  assign n_start      = (no_of_multiples > MAX_CNT) ? MAX_CNT : no_of_multiples;
  assign wr_ok        = ({1'b0, wr_addr} < (AW + 1)'(MEM_DEPTH));

  // Chunk k sits k slices below the MSB; shift it up to the top and slice there.
  assign issue_sel = (issue_q < MAX_CNT) ? issue_q : '0;
  assign col_sh    = col_q << (CHUNK_W * issue_sel);
  assign chunk_idx = col_sh[COL_W-1 -: CHUNK_W];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [IDX_W-1:0]  idx, word;
    logic [WORD_W-1:0] sel_sh;

    assign idx       = chunk_idx[j*IDX_W +: IDX_W];
    assign word      = idx >> SHIFT;
    assign off_d[j]  = RW'(idx & OFF_MASK);
    assign oob_d[j]  = (idx != INVALID) && (word >= DEPTH_IDX);
    assign inv_d[j]  = (idx == INVALID) || (word >= DEPTH_IDX);
    assign word_d[j] = inv_d[j] ? '0 : AW'(word);

    // Element 0 is MSB-most, so shifting left by r elements brings element r to the top.
    assign sel_sh = s2_data_q[j] << (ELEM_W * s2_off_q[j]);
    assign out_row[j*ELEM_W +: ELEM_W] =
        (s2_valid_q && !s2_inv_q[j]) ? sel_sh[WORD_W-1 -: ELEM_W] : '0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (n_start == '0) ? StDrain : StIssue;
      StIssue: if (advance && issue_last) state_d = StDrain;
      StDrain: if (!s1_valid_q && (!s2_valid_q || out_ready)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign start_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign out_valid   = s2_valid_q;
  assign out_chunk   = s2_chunk_q;
  assign out_last    = s2_valid_q && s2_last_q;
  assign oob_err     = oob_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      n_q        <= '0;
      issue_q    <= '0;
      oob_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_chunk_q <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_chunk_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        n_q     <= n_start;
        issue_q <= '0;
      end else if (issue_en) begin
        issue_q <= issue_q + CNT_W'(1);
      end
      if (advance) begin
        s1_valid_q <= issue_en;
        s1_chunk_q <= issue_q;
        s1_last_q  <= issue_last;
        s2_valid_q <= s1_valid_q;
        s2_chunk_q <= s1_chunk_q;
        s2_last_q  <= s1_last_q;
      end
      if (issue_en && |oob_d) oob_q <= 1'b1;
    end
  end

  // Datapath registers are qualified by the valids above and need no reset.
  always_ff @(posedge clk) begin
    if (accept_start) col_q <= col_nos;
    if (advance) begin
      for (int j = 0; j < LANES; j++) begin
        s1_word_q[j] <= word_d[j];
        s1_off_q[j]  <= off_d[j];
        s2_data_q[j] <= mem[s1_word_q[j]];
        s2_off_q[j]  <= s1_off_q[j];
      end
      s1_inv_q <= inv_d;
      s2_inv_q <= s1_inv_q;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) mem[wr_addr] <= wr_data;
  end

endmodule

// File: doc/p_emap_gather.md
Name: p_emap_gather

Overview:
- Parametrised successor to the 8-lane element-map gather unit.
- Takes a packed vector of column indices split into `no_of_multiples` chunks of LANES indices each, and splits every index into word address (index / UNITS) and lane offset (index % UNITS).
- Reads the packed vector memory for each index, selects the addressed element, and emits one gathered row per chunk over a valid/ready stream with full backpressure.
- Memory is loadable through a write port; sits between the index-matrix fetch and the multiply-accumulate units.

Parameters:
- LANES, 8, gathered elements per output row (≥1).
- UNITS, 8, elements per memory word; power of two.
- ELEM_W, 32, element width.
- IDX_W, 32, column-index width.
- MAX_CHUNKS, 4, maximum chunks per transaction.
- MEM_DEPTH, 1024, memory words.
- INVALID, all-ones of IDX_W, index value meaning "no element".
- CNT_W, clog2(MAX_CHUNKS)+1, chunk-count width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- wr_en  in  1  memory write strobe.
- wr_addr  in  clog2(MEM_DEPTH)  memory write word address.
- wr_data  in  UNITS*ELEM_W  memory write data.
- start  in  1  transaction request.
- start_ready  out  1  high in IDLE; start is accepted on start&&start_ready.
- col_nos  in  MAX_CHUNKS*LANES*IDX_W  indices; chunk k occupies the k-th LANES*IDX_W slice from the MSB; lane j at bits [j*IDX_W +: IDX_W] within that slice.
- no_of_multiples  in  CNT_W  chunks in this transaction.
- out_valid  out  1  out_row valid.
- out_ready  in  1  consumer accepts row.
- out_row  out  LANES*ELEM_W  gathered row; lane j at [j*ELEM_W +: ELEM_W].
- out_chunk  out  CNT_W  chunk number of out_row, 0-based.
- out_last  out  1  out_row is the final chunk.
- oob_err  out  1  sticky; an index had word address ≥ MEM_DEPTH.
- busy  out  1  transaction in flight.

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM goes to IDLE; all pipeline valids and counters clear.
  - Outputs after reset: out_valid=0, out_row=0, out_chunk=0, out_last=0, oob_err=0, busy=0, start_ready=1.
  - Memory contents are preserved.
  - A reset mid-transaction drops all in-flight rows silently.
- FSM states:
  - IDLE: start_ready=1. On an accepted start, col_nos and no_of_multiples are captured into internal registers and the FSM moves to ISSUE.
  - ISSUE: one chunk enters stage S1 per unstalled cycle. The issue counter runs 0..N-1; after chunk N-1 is issued the FSM moves to DRAIN.
  - DRAIN: waits until both pipeline stages are empty and the last row is accepted, then moves to IDLE.
- Chunk count N: N = no_of_multiples clamped to MAX_CHUNKS. If no_of_multiples=0, start is accepted, no rows are produced, and the FSM returns to IDLE after one cycle.
- Pipeline:
  - S1 registers, per lane: word = idx>>log2(UNITS); lane offset r = idx & (UNITS-1); a lane-invalid flag if idx==INVALID or word≥MEM_DEPTH.
  - S2 registers: mem[word], r, the invalid flags, chunk number and last flag.
  - Output select: lane value = word[(UNITS-1-r)*ELEM_W +: ELEM_W] (element 0 is MSB-most). Invalid lanes output 0.
- Latency and throughput: an accepted start at edge E0 makes chunk 0 visible (out_valid=1) after edge E2. Without stalls, one row is produced per cycle.
- Backpressure: when out_valid && !out_ready, S1, S2 and the issue counter freeze. out_row, out_chunk and out_last hold stable until accepted.
- oob_err: set when an out-of-range (non-INVALID) index reaches S1. Cleared only by reset.
- busy: 1 from start acceptance until the last row is accepted.
- Memory write/read interaction:
  - Writes are allowed at any time and take effect at the next edge.
  - A read of the same word in the same cycle returns the old data.
  - Writes with wr_addr ≥ MEM_DEPTH are ignored.
- start while not in IDLE is ignored, since start_ready=0.
- Arithmetic is unsigned; no division hardware is used (shift/mask only, because UNITS is a power of two).

Test Plan:
- Smoke gather: LANES=8, UNITS=8. Load word0=elements 0..7 with values 0x100..0x107 and word1=0x108..0x10F. Chunk0 indices lanes0..7={0,9,2,15,INVALID,8,7,1}, N=1. Required: after 2 edges, one row = {0x100,0x109,0x102,0x10F,0,0x108,0x107,0x101}, out_last=1, out_chunk=0.
- Multi-chunk streaming: N=4, out_ready=1 throughout. Required: 4 rows on consecutive cycles, out_chunk 0..3, out_last only on chunk 3; busy falls the cycle after chunk 3 is accepted.
- Backpressure: N=3, out_ready low for 5 cycles while chunk 0 is presented. Required: chunk 0 and its data held stable; afterwards chunks 1 and 2 arrive in order with no loss or duplication.
- Boundaries:
  - no_of_multiples=0: no rows produced.
  - no_of_multiples=7 (MAX_CHUNKS=4): exactly 4 rows.
  - Index 1024*8 (word 1024 = MEM_DEPTH): lane outputs 0 and oob_err sets and stays set.
- Reset mid-transaction: assert rst_n=0 for one edge during chunk 1 of N=4. Required: out_valid=0 and busy=0 next cycle, start_ready=1. A new start then returns correct data (memory retained).
- Write/read collision: write word0 in the same cycle the S2 read of word0 occurs. Required: the row carries the old value; the next transaction returns the new value.
